// File: rtl/instruction_sequencer.sv
// Fetch stage feeding the cpu: loadable program memory that issues one word per clock
// after start, stalls on a busy tensor core, and halts on a zero word, the issue limit or end of memory.
module instruction_sequencer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DEPTH             = 1024,
  parameter int ADDRESS_WIDTH     = 10,
  parameter int MAX_INSTRUCTIONS  = 100
) (
  input  logic                         clock_in,
  input  logic                         reset_n_in,
  input  logic                         load_enable_in,
  input  logic [ADDRESS_WIDTH-1:0]     load_address_in,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data_in,
  input  logic                         start_in,
  input  logic                         stall_in,
  output logic [INSTRUCTION_WIDTH-1:0] current_instruction,
  output logic                         instruction_valid,
  output logic [ADDRESS_WIDTH-1:0]     program_counter,
  output logic [ADDRESS_WIDTH:0]       instruction_count,
  output logic                         busy,
  output logic                         halted
);
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_HALT} state_t;

  state_t                       r_state;
  logic [INSTRUCTION_WIDTH-1:0] r_mem [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] r_fetch;
  logic [INSTRUCTION_WIDTH-1:0] r_instruction;
  logic                         r_valid;
  logic [ADDRESS_WIDTH-1:0]     r_pc;
  logic [ADDRESS_WIDTH:0]       r_count;

  logic                         w_write;
  logic                         w_terminate;
  logic                         w_issue;
  logic                         w_last_address;
  logic                         w_read_enable;
  logic [ADDRESS_WIDTH-1:0]     w_read_address;

  assign w_write        = load_enable_in && ((r_state == S_IDLE) || (r_state == S_HALT));
  assign w_terminate    = (r_fetch == '0) || (32'(r_count) == MAX_INSTRUCTIONS);
  assign w_issue        = (r_state == S_RUN) && !w_terminate && !stall_in;
  assign w_last_address = (r_pc == ADDRESS_WIDTH'(DEPTH - 1));
  // Reading pc+1 on each issue keeps the fetch word one step ahead, so no stall recovery bubble.
  assign w_read_enable  = (r_state == S_PRIME) || w_issue;
  assign w_read_address = (r_state == S_PRIME) ? '0 : r_pc + ADDRESS_WIDTH'(1);

  // Program memory has no reset so a program survives a reset and can be rerun.
  always_ff @(posedge clock_in) begin
    if (w_write) begin
      r_mem[load_address_in] <= load_data_in;
    end
    if (w_read_enable) begin
      r_fetch <= r_mem[w_read_address];
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      r_state       <= S_IDLE;
      r_instruction <= '0;
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_count       <= '0;
    end else begin
      r_instruction <= '0;
      r_valid       <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start_in) begin
            r_pc    <= '0;
            r_count <= '0;
            r_state <= S_PRIME;
          end
        end
        S_PRIME: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_terminate) begin
            r_state <= S_HALT;
          end else if (!stall_in) begin
            r_instruction <= r_fetch;
            r_valid       <= 1'b1;
            r_count       <= r_count + (ADDRESS_WIDTH + 1)'(1);
            r_pc          <= r_pc + ADDRESS_WIDTH'(1);
            if (w_last_address) begin
              r_state <= S_HALT;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign current_instruction = r_instruction;
  assign instruction_valid   = r_valid;
  assign program_counter     = r_pc;
  assign instruction_count   = r_count;
  assign busy                = (r_state == S_PRIME) || (r_state == S_RUN);
  assign halted              = (r_state == S_HALT);
endmodule
